// File: rtl/simon_playback_sequencer.sv
// simon_playback_sequencer: plays the stored Simon pattern on the lamps and echoes player presses between playbacks
module simon_playback_sequencer #(
  parameter int DEPTH = 16,
  parameter int TICK_DIV = 50_000,
  parameter int ON_TICKS = 8,
  parameter int OFF_TICKS = 4,
  parameter int ECHO_TICKS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   len,
  output logic [$clog2(DEPTH)-1:0] rd_addr,
  input  logic [1:0]               rd_data,
  input  logic                     echo_valid,
  input  logic [1:0]               echo_btn,
  output logic [1:0]               lamp,
  output logic                     lamp_ena,
  output logic                     busy,
  output logic                     done,
  output logic                     tick
);
  localparam int AW = $clog2(DEPTH);
  localparam int MT = ON_TICKS > OFF_TICKS ? (ON_TICKS > ECHO_TICKS ? ON_TICKS : ECHO_TICKS)
                                           : (OFF_TICKS > ECHO_TICKS ? OFF_TICKS : ECHO_TICKS);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int TW = $clog2(MT + 1);
  localparam logic [AW:0] DL = DEPTH[AW:0];
  typedef enum logic [1:0] {IDLE, ON, OFF, ECHO} state_t;
  state_t state_q, state_d;
  logic [AW:0] idx_q, idx_d, cnt_len_q, cnt_len_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] tcnt_q, tcnt_d, n_ticks;
  logic [1:0] lamp_q, lamp_d;
  logic lamp_ena_q, lamp_ena_d, busy_q, busy_d, done_q, done_d, tick_q, tick_d;
  logic wrap, phase_end, enter;
  assign rd_addr = idx_q[AW-1:0];
  assign lamp = lamp_q;
  assign lamp_ena = lamp_ena_q;
  assign busy = busy_q;
  assign done = done_q;
  assign tick = tick_q;
  always_comb begin
    wrap = pre_q == PW'(TICK_DIV - 1);
    n_ticks = state_q == ON ? TW'(ON_TICKS) : state_q == OFF ? TW'(OFF_TICKS) : TW'(ECHO_TICKS);
    phase_end = wrap && tcnt_q == n_ticks - 1'b1;
    state_d = state_q;
    idx_d = idx_q;
    cnt_len_d = cnt_len_q;
    lamp_d = lamp_q;
    done_d = 1'b0;
    enter = 1'b0;
    if (state_q == IDLE || state_q == ECHO) begin
      if (start) begin
        enter = 1'b1;
        done_d = len == '0;
        state_d = len == '0 ? IDLE : ON;
        cnt_len_d = len > DL ? DL : len;
        lamp_d = len == '0 ? lamp_q : rd_data;
      end else if (echo_valid) begin
        enter = 1'b1;
        state_d = ECHO;
        lamp_d = echo_btn;
      end else if (state_q == ECHO && phase_end) begin
        enter = 1'b1;
        state_d = IDLE;
      end
    end else if (phase_end) begin
      enter = 1'b1;
      if (state_q == ON) begin
        state_d = OFF;
        idx_d = idx_q + 1'b1;
      end else if (idx_q == cnt_len_q) begin
        state_d = IDLE;
        done_d = 1'b1;
        idx_d = '0;
      end else begin
        state_d = ON;
        lamp_d = rd_data;
      end
    end
    pre_d = enter || state_d == IDLE || wrap ? '0 : pre_q + 1'b1;
    tcnt_d = enter || state_d == IDLE ? '0 : tcnt_q + TW'(wrap);
    tick_d = wrap && state_q != IDLE && state_d != IDLE;
    lamp_ena_d = state_d == ON || state_d == ECHO;
    busy_d = state_d == ON || state_d == OFF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_len_q <= '0;
      pre_q <= '0;
      tcnt_q <= '0;
      lamp_q <= '0;
      lamp_ena_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_len_q <= cnt_len_d;
      pre_q <= pre_d;
      tcnt_q <= tcnt_d;
      lamp_q <= lamp_d;
      lamp_ena_q <= lamp_ena_d;
      busy_q <= busy_d;
      done_q <= done_d;
      tick_q <= tick_d;
    end
  end
endmodule

// File: tb/tb_simon_playback_sequencer.sv
// tb_simon_playback_sequencer: randomized timeline checks of playback, echo, clamp and reset behaviour
module tb_simon_playback_sequencer;
  localparam int DEPTH = 16, TD = 4, ONT = 2, OFT = 1, ECT = 1, P = (ONT + OFT) * TD;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, echo_valid = 1'b0;
  logic [4:0] len = '0;
  logic [3:0] rd_addr;
  logic [1:0] rd_data, lamp, last_lamp;
  logic [1:0] echo_btn = '0;
  logic lamp_ena, busy, done, tick;
  logic [1:0] mem [DEPTH];
  int checks = 0, errors = 0;
  wire [9:0] obs = {lamp, lamp_ena, busy, done, tick, rd_addr};
  assign rd_data = mem[rd_addr];
  always #5 clk = ~clk;
  simon_playback_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TD), .ON_TICKS(ONT), .OFF_TICKS(OFT), .ECHO_TICKS(ECT)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .rd_addr(rd_addr), .rd_data(rd_data),
    .echo_valid(echo_valid), .echo_btn(echo_btn), .lamp(lamp), .lamp_ena(lamp_ena),
    .busy(busy), .done(done), .tick(tick)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step;
    checks++;
    if (obs !== 10'd0) begin errors++; $display("FAIL reset_hold obs=%b exp=%b", obs, 10'd0); end
    rst = 1'b0;
    step;
    checks++;
    if (obs !== 10'd0) begin errors++; $display("FAIL reset_release obs=%b exp=%b", obs, 10'd0); end
    last_lamp = '0;
  endtask
  task automatic test_playback(input int l, input int mode);
    int eff, i, r;
    logic [1:0] el;
    logic ee, eb, ed, et;
    logic [3:0] ea;
    eff = l > DEPTH ? DEPTH : l;
    if (mode == 3) begin
      echo_valid = 1'b1;
      echo_btn = 2'($urandom);
      step;
      echo_valid = 1'b0;
      checks++;
      if (lamp_ena !== 1'b1) begin errors++; $display("FAIL echo_before_start lamp_ena=%b exp=1", lamp_ena); end
    end
    start = 1'b1;
    len = 5'(l);
    if (mode == 2) begin
      echo_valid = 1'b1;
      echo_btn = ~mem[0];
    end
    step;
    start = 1'b0;
    echo_valid = 1'b0;
    for (int k = 0; k <= eff * P; k++) begin
      if (k == eff * P) begin
        el = mem[eff-1]; ee = 1'b0; eb = 1'b0; ed = 1'b1; et = 1'b0; ea = 4'd0;
      end else begin
        i = k / P;
        r = k % P;
        el = mem[i];
        ee = r < ONT * TD;
        eb = 1'b1;
        ed = 1'b0;
        et = k > 0 && k % TD == 0;
        ea = 4'(r < ONT * TD ? i : (i + 1) % DEPTH);
      end
      checks++;
      if (obs !== {el, ee, eb, ed, et, ea}) begin
        errors++;
        $display("FAIL playback len=%0d mode=%0d k=%0d obs=%b exp=%b", l, mode, k, obs, {el, ee, eb, ed, et, ea});
      end
      if (k < eff * P) begin
        if (mode == 1) begin
          start = 1'($urandom_range(0, 1));
          len = 5'($urandom);
          echo_valid = 1'($urandom_range(0, 1));
          echo_btn = 2'($urandom);
        end
        step;
      end else begin
        start = 1'b0;
        echo_valid = 1'b0;
      end
    end
    last_lamp = mem[eff-1];
  endtask
  task automatic test_zero_len;
    start = 1'b1;
    len = 5'd0;
    step;
    start = 1'b0;
    checks++;
    if (obs !== {last_lamp, 8'b0_0_1_0_0000}) begin errors++; $display("FAIL zero_len_done obs=%b exp=%b", obs, {last_lamp, 8'b00100000}); end
    for (int c = 0; c < 4; c++) begin
      step;
      checks++;
      if (obs !== {last_lamp, 8'd0}) begin errors++; $display("FAIL zero_len_idle c=%0d obs=%b exp=%b", c, obs, {last_lamp, 8'd0}); end
    end
  endtask
  task automatic test_echo;
    logic [1:0] b;
    b = 2'($urandom);
    echo_valid = 1'b1;
    echo_btn = b;
    step;
    echo_valid = 1'b0;
    for (int c = 0; c < ECT * TD; c++) begin
      checks++;
      if (obs !== {b, 8'b1_0_0_0_0000}) begin errors++; $display("FAIL echo_lit c=%0d obs=%b exp=%b", c, obs, {b, 8'b10000000}); end
      step;
    end
    checks++;
    if (obs !== {b, 8'd0}) begin errors++; $display("FAIL echo_end obs=%b exp=%b", obs, {b, 8'd0}); end
    echo_valid = 1'b1;
    echo_btn = 2'd1;
    step;
    echo_valid = 1'b0;
    checks++;
    if (obs !== {2'd1, 8'b10000000}) begin errors++; $display("FAIL echo_first obs=%b exp=%b", obs, {2'd1, 8'b10000000}); end
    step;
    echo_valid = 1'b1;
    echo_btn = 2'd3;
    step;
    echo_valid = 1'b0;
    for (int c = 0; c < ECT * TD; c++) begin
      checks++;
      if (obs !== {2'd3, 8'b10000000}) begin errors++; $display("FAIL echo_restart c=%0d obs=%b exp=%b", c, obs, {2'd3, 8'b10000000}); end
      step;
    end
    checks++;
    if (obs !== {2'd3, 8'd0}) begin errors++; $display("FAIL echo_restart_end obs=%b exp=%b", obs, {2'd3, 8'd0}); end
    last_lamp = 2'd3;
  endtask
  task automatic test_reset_mid;
    start = 1'b1;
    len = 5'd3;
    step;
    start = 1'b0;
    repeat (P + 9) step;
    checks++;
    if (obs !== {mem[1], 8'b0_1_0_0_0010}) begin errors++; $display("FAIL mid_off obs=%b exp=%b", obs, {mem[1], 8'b01000010}); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++;
    if (obs !== 10'd0) begin errors++; $display("FAIL mid_reset obs=%b exp=%b", obs, 10'd0); end
    for (int c = 0; c < 30; c++) begin
      step;
      checks++;
      if (obs !== 10'd0) begin errors++; $display("FAIL post_reset_idle c=%0d obs=%b exp=%b", c, obs, 10'd0); end
    end
    last_lamp = '0;
  endtask
  initial begin
    mem[0] = 2'd2;
    mem[1] = 2'd0;
    mem[2] = 2'd3;
    mem[3] = 2'd1;
    for (int j = 4; j < DEPTH; j++) mem[j] = 2'($urandom);
    test_reset;
    repeat (5) step;
    test_playback(3, 0);
    repeat ($urandom_range(1, 5)) step;
    test_playback($urandom_range(1, 8), 1);
    repeat ($urandom_range(1, 5)) step;
    test_playback($urandom_range(1, 6), 0);
    test_playback($urandom_range(1, 6), 2);
    test_playback($urandom_range(1, 6), 1);
    repeat ($urandom_range(1, 5)) step;
    test_zero_len;
    test_echo;
    test_playback($urandom_range(1, 6), 3);
    repeat ($urandom_range(1, 5)) step;
    test_playback(16, 1);
    repeat ($urandom_range(1, 5)) step;
    test_playback(31, 0);
    repeat ($urandom_range(1, 5)) step;
    test_reset_mid;
    test_playback(3, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/simon_playback_sequencer.md
# simon_playback_sequencer

Sequences the Simon lamp outputs. On a start request it walks the stored pattern memory from entry 0 to `len-1` and shows each colour for a fixed on-time followed by a blank gap. Between playbacks it echoes the player's validated button presses on the same lamps for a short time. It sits between the game controller, the pattern memory and the one-hot lamp decode, and it owns the tick timer that drives the timer-pulse output.

## Interface

**Parameters**
- `DEPTH`, 16: pattern memory entries. Must be a power of two.
- `TICK_DIV`, 50_000: clock cycles per tick. Must be ≥ 1.
- `ON_TICKS`, 8: ticks each pattern colour is lit. Must be ≥ 1.
- `OFF_TICKS`, 4: ticks of blank gap after each colour. Must be ≥ 1.
- `ECHO_TICKS`, 4: ticks a player press is echoed. Must be ≥ 1.

**Ports**
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: playback request. Sampled every cycle.
- `len` in $clog2(DEPTH)+1: number of entries to play. Sampled when `start` is accepted.
- `rd_addr` out $clog2(DEPTH): pattern memory read address.
- `rd_data` in 2: pattern entry. It is a combinational read of `rd_addr`.
- `echo_valid` in 1: one-cycle pulse from the input sync block.
- `echo_btn` in 2: encoded button. Valid only when `echo_valid` is high.
- `lamp` out 2: encoded colour to show.
- `lamp_ena` out 1: lamp drive enable.
- `busy` out 1: high while a playback is in progress.
- `done` out 1: one-cycle pulse when a playback completes.
- `tick` out 1: one-cycle pulse at each tick boundary. It drives the timer-pulse pin.

## Operation
- **States:** IDLE, ON, OFF, ECHO.
- **Registers:**
  - `idx`: entry index, drives `rd_addr`.
  - `cnt_len`: latched length.
  - `pre`: prescaler, counts 0..TICK_DIV-1.
  - `tcnt`: tick counter within the current phase.
- **Phase timer:** `pre` and `tcnt` both clear on every state entry, so phase timing does not depend on prior history. `tick` pulses when `pre` wraps. `tick` is held low in IDLE.
- **IDLE:** `idx` = 0, `lamp_ena` = 0.
  - `start` with `len` = 0: go to IDLE, pulse `done` next cycle, never light a lamp.
  - `start` with `len` ≥ 1: latch `min(len, DEPTH)` into `cnt_len`, latch `lamp <= rd_data` (entry 0), go to ON.
  - `echo_valid` without `start`: latch `lamp <= echo_btn`, go to ECHO.
  - `start` and `echo_valid` in the same cycle: `start` wins and the echo is dropped.
- **ON:** `lamp_ena` = 1.
  - After ON_TICKS ticks: go to OFF and increment `idx`.
- **OFF:** `lamp_ena` = 0.
  - After OFF_TICKS ticks, if `idx` == `cnt_len`: go to IDLE and pulse `done`.
  - Otherwise: latch `lamp <= rd_data` and go to ON.
- **ECHO:** `lamp_ena` = 1.
  - After ECHO_TICKS ticks: go to IDLE.
  - `echo_valid` here: re-latch `echo_btn` and restart the ECHO phase.
  - `start` here: abort the echo and take the IDLE `start` action.
- **Ignored inputs:** `start` and `echo_valid` have no effect while in ON or OFF.
- **busy:** 1 exactly in ON and OFF.
- **lamp:** holds its last value when `lamp_ena` = 0. Downstream logic must gate on `lamp_ena`.
- **Index width:** `idx` is $clog2(DEPTH)+1 bits so that `idx` == DEPTH can be compared. `rd_addr` is its low bits and wraps to 0 at DEPTH. That address is never consumed.

## Timing
- **Reset:** `rst` high at a clock edge forces IDLE on the next edge, including mid-playback and mid-echo. The reset values are:
  - `idx` = 0, `rd_addr` = 0, `lamp` = 0, `lamp_ena` = 0
  - `busy` = 0, `done` = 0, `tick` = 0
  - `pre` = 0, `tcnt` = 0
- **All outputs are registered.** No combinational path from inputs to outputs.
- **Phase length:** each phase lasts exactly N·TICK_DIV cycles, where N is that phase's tick count.
- **Playback timing:** let `start` be accepted at cycle t with L = min(`len`, DEPTH).
  - `lamp_ena` is high in cycles t+1 .. t+ON_TICKS·TICK_DIV.
  - Entry i is lit starting at cycle t+1+i·(ON_TICKS+OFF_TICKS)·TICK_DIV.
  - `done` = 1 and `busy` = 0 in cycle t+1+L·(ON_TICKS+OFF_TICKS)·TICK_DIV.
- **Back-to-back playback:** `start` is next accepted in the same cycle that `done` is high.
- **Echo timing:** with `echo_valid` at cycle t in IDLE, `lamp_ena` is high in cycles t+1 .. t+ECHO_TICKS·TICK_DIV.

## Test plan
All scenarios use TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1, ECHO_TICKS=1, DEPTH=16. The memory holds 2,0,3,1,….

1. **Basic playback.** `start` with `len`=3 at cycle 10.
   - `lamp`=2 with `lamp_ena` high in cycles 11–18.
   - Blank in cycles 19–22.
   - `lamp`=0 lit in 23–30; `lamp`=3 lit in 35–42.
   - `done` in cycle 47; `busy` high in cycles 11–46.
   - `tick` pulses every 4 cycles while busy.
2. **Zero length.** `start` with `len`=0.
   - `done` the next cycle.
   - `lamp_ena` and `busy` never go high.
3. **Echo.**
   - `echo_valid` with `echo_btn`=1 in IDLE: `lamp`=1 with `lamp_ena` high for 4 cycles.
   - A second `echo_valid` with `echo_btn`=3 two cycles in: `lamp`=3, and the 4-cycle window restarts.
   - `echo_valid` during playback: no change to `lamp` or the phase timing.
4. **Simultaneous events.**
   - `start` and `echo_valid` in the same IDLE cycle: playback begins and no echo is shown.
   - `start` during ECHO: the echo aborts and entry 0 is lit on the next cycle.
   - `start` while busy: ignored, with identical `done` timing.
5. **Length clamp and wrap.** `len`=16, and separately `len`=31.
   - Both play exactly 16 entries; `done` at start+193.
   - `rd_addr` visits 0..15 and then 0.
6. **Reset mid-operation.** `rst` high during the OFF of entry 1.
   - All outputs take their reset values on the next cycle; no `done` pulse.
   - A fresh `start` then replays from entry 0 with nominal timing.
